mips_fetch_unit: RTL and testbench
==================================

# mips_fetch_unit

Instruction fetch stage feeding the MIPS control decoder and datapath. Holds the program counter, fetches one 32-bit word per instruction over a simple req/ack instruction-memory port, and holds it in an instruction register while the rest of the core executes it. The core returns the decoder's Branch/Jump/JumpReg controls, the ALU branch condition and the register jump target. The unit then selects the next PC and starts the next fetch.

## Interface
- RESET_PC, 32'h0000_3000, PC loaded on reset; must be word aligned.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request; high exactly while state is FETCH.
- imem_addr  out  32  word address of the fetch; equals pc.
- imem_ack  in  1  memory has data; sampled only in FETCH.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- instr  out  32  instruction register. OprCtr=instr[31:26], BrCh=instr[20:16], funct=instr[5:0].
- instr_valid  out  1  high while state is EXEC.
- pc  out  32  address of the instruction in instr.
- link_addr  out  32  pc+4, the jal/jalr write-back value.
- exec_done  in  1  core has finished instr; sampled only in EXEC.
- Branch, Jump, JumpReg  in  1 each  decoder controls for instr.
- br_taken  in  1  ALU branch condition result.
- jr_target  in  32  register value for jr/jalr.
- fetch_err  out  1  sticky misaligned-target error.
- retired  out  32  count of completed instructions.

## Operation
- States: IDLE, FETCH, EXEC, ERR.
- IDLE always moves to FETCH on the next cycle.
- FETCH: imem_req=1. On imem_ack, load instr<=imem_rdata and move to EXEC. Without ack, stay; the request stays high and the address stays stable.
- EXEC: instr, pc and instr_valid are held. On exec_done:
  - retired increments, wrapping at 2^32.
  - next_pc is chosen by priority:
    - JumpReg: jr_target.
    - else Jump: {link_addr[31:28], instr[25:0], 2'b00}.
    - else Branch & br_taken: link_addr + {{14{instr[15]}}, instr[15:0], 2'b00}.
    - else: link_addr.
  - If next_pc[1:0]==0: pc<=next_pc, state→FETCH.
  - Otherwise: pc unchanged, fetch_err<=1, state→ERR.
- ERR: terminal state. imem_req=0, instr_valid=0. Only reset leaves it.
- All adds are 32-bit, modulo 2^32; wrap-around at 0xFFFF_FFFC→0 is legal.
- Branch with br_taken=0 behaves as sequential. Control inputs are ignored outside EXEC, and when exec_done=0.
- No delay slot: branch offset base and link value are both pc+4.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, retired=0.
- First request appears in the 2nd cycle after the rst_n-low edge, i.e. IDLE lasts one cycle.
- A zero-wait ack (in the same cycle as req) gives instr_valid on the next cycle.
- Minimum throughput is 2 cycles per instruction (FETCH 1 + EXEC 1). Each memory wait cycle adds 1.
- pc, instr and link_addr change only on the edge that leaves EXEC or FETCH respectively. They are stable throughout EXEC.
- imem_ack outside FETCH and exec_done outside EXEC have no effect.
- rst_n low in any state, including mid-FETCH with req pending, restores reset values on that edge. A pending ack in that cycle is discarded.

## Test plan
- Reset then zero-wait memory returning 0x20080005 at 0x3000 (addi) → imem_req at cycle 2; instr_valid at cycle 3 with pc=0x3000, link_addr=0x3004. exec_done=1 → next imem_addr=0x3004, retired=1.
- imem_ack delayed 3 cycles → imem_req held 4 cycles with imem_addr constant; instr_valid exactly one cycle after ack.
- beq at 0x3008 with imm16=0xFFFF, Branch=1:
  - br_taken=1 → next pc=0x3008.
  - br_taken=0 → next pc=0x300C.
- jal 0x0C000C10 at 0x3010 → link_addr=0x3014, next pc=0x0000_3040. Jump and JumpReg both high with jr_target=0x4000 → next pc=0x4000.
- jr with jr_target=0x3002 → fetch_err=1, state ERR, imem_req stays 0 for 10 cycles, retired incremented. rst_n low → all reset values, then fetch from RESET_PC.
- rst_n low in the same cycle as imem_ack in FETCH → instr=0, pc=RESET_PC, instr_valid=0. The fetch restarts from IDLE.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// Fetch stage: holds PC and instruction register, fetches over a req/ack port, picks next PC from core controls.
// Latency: ack -> instr_valid in 1 cycle, 2 cycles/instr minimum; req held with stable address until ack.
module mips_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] link_addr,
   input  logic        exec_done,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        JumpReg,
   input  logic        br_taken,
   input  logic [31:0] jr_target,
   output logic        fetch_err,
   output logic [31:0] retired
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERR} state_t;

   state_t      state, state_nxt;
   logic [31:0] next_pc;
   logic [31:0] br_off;
   logic        load_instr, retire, pc_load, err_set;

   assign link_addr = pc + 32'd4;
   assign imem_addr = pc;
   assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};

   // No delay slot: both the branch base and the jump region come from pc+4.
   always_comb begin
      next_pc = link_addr;
      if (JumpReg)
         next_pc = jr_target;
      else if (Jump)
         next_pc = {link_addr[31:28], instr[25:0], 2'b00};
      else if (Branch && br_taken)
         next_pc = link_addr + br_off;
   end

   always_comb begin
      state_nxt   = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      load_instr  = 1'b0;
      retire      = 1'b0;
      pc_load     = 1'b0;
      err_set     = 1'b0;
      case (state)
         IDLE:  state_nxt = FETCH;
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               load_instr = 1'b1;
               state_nxt  = EXEC;
            end
         end
         EXEC: begin
            instr_valid = 1'b1;
            if (exec_done) begin
               retire = 1'b1;
               if (next_pc[1:0] == 2'b00) begin
                  pc_load   = 1'b1;
                  state_nxt = FETCH;
               end else begin
                  err_set   = 1'b1;
                  state_nxt = ERR;
               end
            end
         end
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         instr     <= 32'd0;
         fetch_err <= 1'b0;
         retired   <= 32'd0;
      end else begin
         state <= state_nxt;
         if (load_instr) instr     <= imem_rdata;
         if (pc_load)    pc        <= next_pc;
         if (retire)     retired   <= retired + 32'd1;
         if (err_set)    fetch_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: expected fetch addresses are queued when exec_done is driven and popped on each request.
module tb_mips_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic        exec_done;
   logic        Branch, Jump, JumpReg, br_taken;
   logic [31:0] jr_target;
   logic        fetch_err;
   logic [31:0] retired;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] addr_q[$];
   logic [31:0] exp_ret;

   mips_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .link_addr   (link_addr),
      .exec_done   (exec_done),
      .Branch      (Branch),
      .Jump        (Jump),
      .JumpReg     (JumpReg),
      .br_taken    (br_taken),
      .jr_target   (jr_target),
      .fetch_err   (fetch_err),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, "_pc"}, pc, 32'h0000_3000);
      chk({tag, "_instr"}, instr, 32'd0);
      chk({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
      chk({tag, "_retired"}, retired, 32'd0);
   endtask

   // Entered one step after an edge with the DUT in FETCH; leaves one step after the exec_done edge.
   task automatic fetch_exec(input logic [31:0] word, input int waits,
                             input logic br, input logic j, input logic jr, input logic tk,
                             input logic [31:0] jrt, input logic [31:0] exp_npc);
      logic [31:0] epc;
      logic        ok;
      if (addr_q.size() == 0) begin
         chk("addr_q_empty", 32'd1, 32'd0);
         return;
      end
      epc = addr_q.pop_front();
      chk("req", {31'd0, imem_req}, 32'd1);
      chk("addr", imem_addr, epc);
      chk("err_clear", {31'd0, fetch_err}, 32'd0);
      for (int i = 0; i < waits; i++) begin
         imem_ack = 1'b0;
         step();
         chk("req_wait", {31'd0, imem_req}, 32'd1);
         chk("addr_wait", imem_addr, epc);
         chk("valid_wait", {31'd0, instr_valid}, 32'd0);
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      step();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      chk("valid", {31'd0, instr_valid}, 32'd1);
      chk("instr", instr, word);
      chk("pc", pc, epc);
      chk("link", link_addr, epc + 32'd4);
      chk("req_exec", {31'd0, imem_req}, 32'd0);
      // Stall cycle: stray ack and random controls must be ignored.
      Branch    = 1'($urandom_range(0, 1));
      Jump      = 1'($urandom_range(0, 1));
      JumpReg   = 1'($urandom_range(0, 1));
      br_taken  = 1'($urandom_range(0, 1));
      jr_target = $urandom;
      imem_ack  = 1'b1;
      step();
      imem_ack = 1'b0;
      chk("valid_hold", {31'd0, instr_valid}, 32'd1);
      chk("instr_hold", instr, word);
      chk("pc_hold", pc, epc);
      Branch    = br;
      Jump      = j;
      JumpReg   = jr;
      br_taken  = tk;
      jr_target = jrt;
      exec_done = 1'b1;
      exp_ret   = exp_ret + 32'd1;
      ok        = (exp_npc[1:0] == 2'b00);
      if (ok) addr_q.push_back(exp_npc);
      step();
      exec_done = 1'b0;
      Branch    = 1'b0;
      Jump      = 1'b0;
      JumpReg   = 1'b0;
      br_taken  = 1'b0;
      chk("retired", retired, exp_ret);
      chk("err_after", {31'd0, fetch_err}, {31'd0, !ok});
      chk("req_after", {31'd0, imem_req}, {31'd0, ok});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; exec_done = 1'b0;
      Branch = 1'b0; Jump = 1'b0; JumpReg = 1'b0; br_taken = 1'b0; jr_target = 32'd0;
      exp_ret = 32'd0;
      step();
      reset_checks("rst");
      rst_n = 1'b1;
      addr_q.push_back(32'h0000_3000);
      step();

      fetch_exec(32'h2008_0005, 0, 0, 0, 0, 0, 0, 32'h0000_3004);
      fetch_exec(32'h0109_5020, 3, 0, 0, 0, 0, 0, 32'h0000_3008);
      fetch_exec(32'h1000_FFFF, 0, 1, 0, 0, 1, 0, 32'h0000_3008);
      fetch_exec(32'h1000_FFFF, 1, 1, 0, 0, 0, 0, 32'h0000_300C);
      fetch_exec(32'h0000_0000, 0, 0, 0, 0, 0, 0, 32'h0000_3010);
      fetch_exec(32'h0C00_0C10, 0, 0, 1, 0, 0, 0, 32'h0000_3040);
      fetch_exec(32'h0C00_0C10, 0, 0, 1, 1, 0, 32'h0000_4000, 32'h0000_4000);
      fetch_exec(32'h1109_0004, 2, 1, 0, 0, 1, 0, 32'h0000_4014);
      fetch_exec(32'h03E0_0008, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
      fetch_exec(32'h0000_0000, 1, 0, 0, 0, 0, 0, 32'h0000_0000);
      fetch_exec(32'h03E0_0008, 0, 0, 0, 1, 0, 32'h0000_3002, 32'h0000_3002);

      // Terminal error state ignores all stimulus.
      for (int i = 0; i < 10; i++) begin
         imem_ack  = 1'b1;
         exec_done = 1'b1;
         JumpReg   = 1'($urandom_range(0, 1));
         step();
         chk("err_req", {31'd0, imem_req}, 32'd0);
         chk("err_valid", {31'd0, instr_valid}, 32'd0);
         chk("err_sticky", {31'd0, fetch_err}, 32'd1);
         chk("err_retired", retired, exp_ret);
         chk("err_pc", pc, 32'h0000_0000);
      end
      imem_ack = 1'b0; exec_done = 1'b0; JumpReg = 1'b0;

      rst_n = 1'b0;
      step();
      reset_checks("rst_err");
      addr_q.delete();
      addr_q.push_back(32'h0000_3000);
      exp_ret = 32'd0;
      rst_n = 1'b1;
      step();
      fetch_exec(32'h2008_0005, 2, 0, 0, 0, 0, 0, 32'h0000_3004);

      // Reset coinciding with an ack in FETCH discards the fetched word.
      chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      rst_n      = 1'b0;
      step();
      imem_ack = 1'b0;
      reset_checks("rst_ack");
      addr_q.delete();
      addr_q.push_back(32'h0000_3000);
      exp_ret = 32'd0;
      rst_n = 1'b1;
      step();
      fetch_exec(32'h2008_0005, 0, 0, 0, 0, 0, 0, 32'h0000_3004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
